// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and constants for the APB master arbiter.
// Holds the transfer FSM states, requester count and default timeout.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int NUM_REQ         = 2;
    localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant.
// i_last=1 means requester 1 won last, so requester 0 wins a tie.
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    // One-hot grant; a tie goes to the requester that lost last time
    always_comb begin
        o_gnt = 2'b00;
        unique case (1'b1)
            i_req[0] && (!i_req[1] || i_last):  o_gnt = 2'b01;
            i_req[1] && (!i_req[0] || !i_last): o_gnt = 2'b10;
            default:                            o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester APB master with round-robin grant.
// One transfer at a time; ACCESS aborts after TIMEOUT_CYC wait cycles.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic                      PREADY,
    input  logic [DATA_W-1:0]         PRDATA
);

    localparam int               CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t               r_state, w_state_nxt;
    logic                 r_gnt, w_gnt_nxt;
    logic                 r_last, w_last_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                 r_psel, w_psel_nxt;
    logic                 r_penable, w_penable_nxt;
    logic                 r_pwrite, w_pwrite_nxt;
    logic [ADDR_W-1:0]    r_paddr, w_paddr_nxt;
    logic [DATA_W-1:0]    r_pwdata, w_pwdata_nxt;
    logic [NUM_REQ-1:0]   r_done, w_done_nxt;
    logic                 r_err, w_err_nxt;
    logic [DATA_W-1:0]    r_rdata, w_rdata_nxt;

    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_win;
    logic [ADDR_W-1:0]    w_win_addr;
    logic [DATA_W-1:0]    w_win_wdata;

    rr_arbiter2 u_rr (
        .i_req  (req),
        .i_last (r_last),
        .o_gnt  (w_grant)
    );

    assign w_win       = w_grant[1];
    assign w_win_addr  = w_win ? req_addr[2*ADDR_W-1:ADDR_W]
                               : req_addr[ADDR_W-1:0];
    assign w_win_wdata = w_win ? req_wdata[2*DATA_W-1:DATA_W]
                               : req_wdata[DATA_W-1:0];

    // Next state and next value of every registered output
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_pwrite_nxt  = r_pwrite;
        w_paddr_nxt   = r_paddr;
        w_pwdata_nxt  = r_pwdata;
        w_done_nxt    = '0;
        w_err_nxt     = r_err;
        w_rdata_nxt   = r_rdata;
        unique case (r_state)
            IDLE: begin
                if (|w_grant) begin
                    w_state_nxt  = SETUP;
                    w_gnt_nxt    = w_win;
                    w_last_nxt   = w_win;
                    w_psel_nxt   = 1'b1;
                    w_pwrite_nxt = req_write[w_win];
                    w_paddr_nxt  = w_win_addr;
                    w_pwdata_nxt = w_win_wdata;
                end
            end
            SETUP: begin
                w_state_nxt   = ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end
            ACCESS: begin
                if (PREADY) begin
                    w_state_nxt       = IDLE;
                    w_done_nxt[r_gnt] = 1'b1;
                    w_err_nxt         = 1'b0;
                    w_rdata_nxt       = r_pwrite ? '0 : PRDATA;
                    w_cnt_nxt         = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt       = IDLE;
                    w_done_nxt[r_gnt] = 1'b1;
                    w_err_nxt         = 1'b1;
                    w_rdata_nxt       = '0;
                    w_cnt_nxt         = '0;
                end else begin
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b1;
                    w_cnt_nxt     = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer silently
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= IDLE;
            r_gnt     <= 1'b0;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_rdata   <= w_rdata_nxt;
        end
    end

    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;
    assign done    = r_done;
    assign err     = r_err;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed and random checks of the APB arbiter
// against a transfer-level model held in the bench.
module tb_apb_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          PCLK      = 1'b0;
    logic          PRESETn   = 1'b1;
    logic [1:0]    req       = '0;
    logic [1:0]    req_write = '0;
    logic [2*AW-1:0] req_addr  = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]    done;
    logic          err;
    logic [DW-1:0] rdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY    = 1'b0;
    logic [DW-1:0] PRDATA    = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 PCLK = ~PCLK;

    apb_master_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transfer-level model: a transfer is owned by one winner and lasts
    // one SETUP cycle plus up to TO ACCESS cycles.
    logic          m_busy = 1'b0;
    logic          m_setup = 1'b0;
    int            m_acc = 0;
    logic          m_win = 1'b0;
    logic          m_prio = 1'b0;
    logic [1:0]    e_done = '0;
    logic          e_err = 1'b0;
    logic [DW-1:0] e_rdata = '0;
    logic          e_psel = 1'b0;
    logic          e_pen = 1'b0;
    logic          e_pwrite = 1'b0;
    logic [AW-1:0] e_paddr = '0;
    logic [DW-1:0] e_pwdata = '0;

    initial forever begin
        @(posedge PCLK or negedge PRESETn);
        if (!PRESETn) begin
            m_busy = 0; m_setup = 0; m_acc = 0; m_prio = 0;
            e_done = '0; e_err = 0; e_rdata = '0;
            e_psel = 0; e_pen = 0; e_pwrite = 0;
            e_paddr = '0; e_pwdata = '0;
        end else begin
            e_done = '0;
            if (!m_busy) begin
                if (req != 2'b00) begin
                    m_win    = (req == 2'b11) ? m_prio : req[1];
                    m_prio   = !m_win;
                    m_busy   = 1;
                    m_setup  = 1;
                    m_acc    = 0;
                    e_pwrite = req_write[m_win];
                    e_paddr  = m_win ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
                    e_pwdata = m_win ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
                    e_psel   = 1;
                    e_pen    = 0;
                end
            end else if (m_setup) begin
                m_setup = 0;
                e_pen   = 1;
            end else begin
                m_acc++;
                if (PREADY || m_acc == TO) begin
                    e_done[m_win] = 1'b1;
                    e_err   = !PREADY;
                    e_rdata = (PREADY && !e_pwrite) ? PRDATA : '0;
                    m_busy  = 0;
                    e_psel  = 0;
                    e_pen   = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge PCLK);
        chk("psel", PSEL, e_psel);
        chk("penable", PENABLE, e_pen);
        chk("done", done, e_done);
        chk("pwrite", PWRITE, e_pwrite);
        chk("paddr", PADDR, e_paddr);
        chk("pwdata", PWDATA, e_pwdata);
        if (e_done != 2'b00 || !PRESETn) begin
            chk("err", err, e_err);
            chk("rdata", rdata, e_rdata);
        end
    end

    task automatic rand_phase(input int ncyc, input int p_rdy);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge PCLK);
            for (int i = 0; i < 2; i++) begin
                if (e_done[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
            end
            req_write = 2'($urandom);
            req_addr  = {$urandom, $urandom};
            req_wdata = {$urandom, $urandom};
            PREADY    = ($urandom_range(0, 99) < p_rdy);
            PRDATA    = $urandom;
        end
    endtask

    int g[4];
    int n;

    initial begin
        #1 PRESETn = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        PRESETn = 1'b1;

        // Write by requester 0, ready in first ACCESS cycle
        @(negedge PCLK);
        req = 2'b01; req_write = 2'b01;
        req_addr[AW-1:0] = 32'h10;
        req_wdata[DW-1:0] = 32'hA5A5_0001;
        PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF;
        @(negedge PCLK);
        chk("t1_setup_psel", PSEL, 1);
        chk("t1_setup_pen", PENABLE, 0);
        chk("t1_paddr", PADDR, 32'h10);
        chk("t1_pwrite", PWRITE, 1);
        req_addr = '1; req_wdata = '0; req_write = 2'b00;
        @(negedge PCLK);
        chk("t1_access_psel", PSEL, 1);
        chk("t1_access_pen", PENABLE, 1);
        chk("t1_pwdata", PWDATA, 32'hA5A5_0001);
        @(negedge PCLK);
        chk("t1_done", done, 2'b01);
        chk("t1_err", err, 0);
        chk("t1_rdata", rdata, 0);
        chk("t1_idle_psel", PSEL, 0);
        req = 2'b00;

        // Read by requester 1 with three wait cycles
        @(negedge PCLK);
        req = 2'b10; req_write = 2'b00;
        req_addr[2*AW-1:AW] = 32'h08;
        PREADY = 1'b0; PRDATA = 32'h1111_2222;
        @(negedge PCLK);
        req_addr = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge PCLK);
            chk("t2_paddr", PADDR, 32'h08);
            chk("t2_pen", PENABLE, 1);
            chk("t2_nodone", done, 0);
        end
        PREADY = 1'b1; PRDATA = 32'h0000_00FF;
        @(negedge PCLK);
        chk("t2_done", done, 2'b10);
        chk("t2_rdata", rdata, 32'hFF);
        chk("t2_err", err, 0);
        req = 2'b00;

        // Both requesting for four transfers: alternate 0,1,0,1
        @(negedge PCLK);
        req = 2'b11; req_write = 2'b00; PREADY = 1'b1; PRDATA = 32'h1234;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge PCLK);
            if (done != 2'b00) begin
                chk("t3_onehot", 64'($onehot(done)), 1);
                g[n] = int'(done[1]);
                n++;
            end
        end
        req = 2'b00;
        chk("t3_count", n, 4);
        for (int k = 0; k < 4; k++) chk("t3_order", g[k], k % 2);

        // Timeout with PREADY stuck low
        @(negedge PCLK);
        req = 2'b01; req_write = 2'b00; PREADY = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        for (int k = 1; k <= TO; k++) begin
            @(negedge PCLK);
            if (k < TO) chk("t4_wait_psel", PSEL, 1);
        end
        chk("t4_done", done, 2'b01);
        chk("t4_err", err, 1);
        chk("t4_rdata", rdata, 0);
        chk("t4_psel", PSEL, 0);
        req = 2'b00;

        // PREADY on the timeout edge wins
        @(negedge PCLK);
        req = 2'b10; PREADY = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        for (int k = 1; k < TO; k++) @(negedge PCLK);
        PREADY = 1'b1; PRDATA = 32'hCAFE;
        @(negedge PCLK);
        chk("t4b_done", done, 2'b10);
        chk("t4b_err", err, 0);
        chk("t4b_rdata", rdata, 32'hCAFE);
        req = 2'b00;

        // Reset during ACCESS: immediate idle, no done, priority back to 0
        @(negedge PCLK);
        req = 2'b01; PREADY = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("t5_in_access", PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("t5_async_psel", PSEL, 0);
        chk("t5_async_pen", PENABLE, 0);
        chk("t5_async_done", done, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        req = 2'b11; PREADY = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        @(negedge PCLK);
        chk("t5_tie_to_0", done, 2'b01);
        req = 2'b00;

        // Random traffic: mostly-ready, then mostly-stalled with timeouts
        rand_phase(1500, 40);
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        req = 2'b00;
        rand_phase(1500, 4);
        req = 2'b00;
        repeat (TO + 4) @(negedge PCLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
